node_fifo: RTL and testbench

Parametrised elastic valid/ready pipeline node, the successor to the single-register node family. It holds up to DEPTH data beats in a circular buffer. It fully decouples upstream and downstream: no combinational path exists from ready_down_in to ready_up_out, nor from valid_up_in to valid_down_out. It drops into any node chain in place of a single-stage node, port-for-port, and adds occupancy status outputs.

---
 rtl/node_fifo.sv | 107 ++++++++++
 tb/tb_node_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/node_fifo.sv
// node_fifo: elastic valid/ready node with a DEPTH-entry circular buffer.
// Registered outputs only; no combinational path across the node.
module node_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    output logic             ready_up_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    input  logic             ready_down_in,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_LVL);

    if (DEPTH < 2) begin : g_depth_chk
        $error("node_fifo: DEPTH must be >= 2");
    end

    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_afull_chk
        $error("node_fifo: AFULL_LVL must be in 1..DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dout_q;

    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] dout_nxt;

    logic push;
    logic pop;

    assign ready_up_out   = (cnt_q != CNT_FULL);
    assign valid_down_out = (cnt_q != '0);
    assign almost_full    = (cnt_q >= CNT_AF);
    assign count          = cnt_q;
    assign data_out       = dout_q;

    assign push = valid_up_in & ready_up_out;
    assign pop  = valid_down_out & ready_down_in;

    always_comb begin
        wr_nxt   = wr_ptr;
        rd_nxt   = rd_ptr;
        cnt_nxt  = cnt_q;
        dout_nxt = dout_q;

        if (push) begin
            wr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt_q + CW'(1);
            2'b01:   cnt_nxt = cnt_q - CW'(1);
            default: cnt_nxt = cnt_q;
        endcase

        // Head register: forward the beat being written if it becomes head.
        if (cnt_nxt != '0) begin
            if (push && (rd_nxt == wr_ptr)) begin
                dout_nxt = data_in;
            end else begin
                dout_nxt = mem[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            cnt_q  <= cnt_nxt;
            dout_q <= dout_nxt;
        end
    end

endmodule

// File: tb/tb_node_fifo.sv
// tb_node_fifo: directed checks for node_fifo at DEPTH=4 and DEPTH=3.
// Both instances share inputs; each is checked where relevant.
module tb_node_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        vin;
    logic        rdy;

    logic        a_rdy_up;
    logic [31:0] a_dout;
    logic        a_vout;
    logic [2:0]  a_cnt;
    logic        a_af;

    logic        b_rdy_up;
    logic [31:0] b_dout;
    logic        b_vout;
    logic [1:0]  b_cnt;
    logic        b_af;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    node_fifo #(.WIDTH(32), .DEPTH(4), .AFULL_LVL(3)) u_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (din),
        .valid_up_in    (vin),
        .ready_up_out   (a_rdy_up),
        .data_out       (a_dout),
        .valid_down_out (a_vout),
        .ready_down_in  (rdy),
        .count          (a_cnt),
        .almost_full    (a_af)
    );

    node_fifo #(.WIDTH(32), .DEPTH(3), .AFULL_LVL(2)) u_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (din),
        .valid_up_in    (vin),
        .ready_up_out   (b_rdy_up),
        .data_out       (b_dout),
        .valid_down_out (b_vout),
        .ready_down_in  (rdy),
        .count          (b_cnt),
        .almost_full    (b_af)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vin   = 1'b0;
        rdy   = 1'b0;
        din   = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_q[$];
        int push_k;
        int pop_n;
        int ea;
        int eb;
        logic [31:0] nxt;
        logic [31:0] held;
        logic hold;

        rst_n = 1'b0;
        vin   = 1'b0;
        rdy   = 1'b0;
        din   = '0;
        repeat (10) step();
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_vout", 32'(a_vout), 0);
        chk("rst_rdy_up", 32'(a_rdy_up), 1);
        chk("rst_af", 32'(a_af), 0);
        chk("rst_dout", a_dout, 0);
        rst_n = 1'b1;
        step();

        // single beat
        vin = 1'b1;
        din = 32'hA5A5_0001;
        rdy = 1'b1;
        step();
        vin = 1'b0;
        chk("one_vout", 32'(a_vout), 1);
        chk("one_dout", a_dout, 32'hA5A5_0001);
        chk("one_cnt", 32'(a_cnt), 1);
        step();
        chk("one_cnt0", 32'(a_cnt), 0);
        chk("one_vout0", 32'(a_vout), 0);

        // fill and stall
        rdy = 1'b0;
        vin = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 32'(i);
            step();
            chk("fill_cnt", 32'(a_cnt), 32'(i));
            chk("fill_af", 32'(a_af), (i >= 3) ? 1 : 0);
        end
        chk("full_rdy_up", 32'(a_rdy_up), 0);
        din = 32'd5;
        step();
        chk("full_cnt", 32'(a_cnt), 4);
        chk("full_head", a_dout, 1);

        // drain with one bubble
        rdy    = 1'b1;
        push_k = -1;
        pop_n  = 0;
        for (int k = 0; k < 10; k++) begin
            chk("drain_cnt_le4", 32'(a_cnt <= 3'd4), 1);
            if (a_vout && rdy) begin
                pop_n++;
                chk("drain_data", a_dout, 32'(pop_n));
            end
            if (vin && a_rdy_up) begin
                push_k = k;
            end
            step();
            if (push_k >= 0) vin = 1'b0;
        end
        chk("drain_push_k", 32'(push_k), 1);
        chk("drain_pops", 32'(pop_n), 5);

        // streaming and wrap, both depths
        do_reset();
        rdy = 1'b1;
        ea  = 0;
        eb  = 0;
        for (int c = 0; c < 26; c++) begin
            vin = (c < 20);
            din = 32'(c);
            chk("str_a_v", 32'(a_vout), (c >= 1 && c <= 20) ? 1 : 0);
            chk("str_b_v", 32'(b_vout), (c >= 1 && c <= 20) ? 1 : 0);
            if (a_vout) begin
                chk("str_a_d", a_dout, 32'(ea));
                ea++;
            end
            if (b_vout) begin
                chk("str_b_d", b_dout, 32'(eb));
                eb++;
            end
            step();
        end
        chk("str_a_n", 32'(ea), 20);
        chk("str_b_n", 32'(eb), 20);

        // random ready, alternating valid, scoreboard
        do_reset();
        nxt  = 32'd100;
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 200; c++) begin
            vin = (c % 2 == 0);
            din = nxt;
            rdy = 1'($urandom_range(0, 1));
            if (hold) begin
                chk("hold_v", 32'(a_vout), 1);
                chk("hold_d", a_dout, held);
            end
            hold = a_vout && !rdy;
            held = a_dout;
            if (a_vout && rdy) begin
                chk("sb_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sb_data", a_dout, exp_q.pop_front());
            end
            if (vin && a_rdy_up) begin
                exp_q.push_back(din);
                nxt++;
            end
            step();
        end
        vin = 1'b0;
        rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_vout) begin
                chk("sb_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sb_data", a_dout, exp_q.pop_front());
            end
            step();
        end
        chk("sb_empty", 32'(exp_q.size()), 0);
        chk("sb_cnt0", 32'(a_cnt), 0);

        // reset mid-operation
        do_reset();
        vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 32'h10 + 32'(i);
            step();
        end
        vin = 1'b0;
        chk("mid_cnt3", 32'(a_cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_cnt0", 32'(a_cnt), 0);
        chk("mid_vout0", 32'(a_vout), 0);
        chk("mid_dout0", a_dout, 0);
        step();
        rst_n = 1'b1;
        vin = 1'b1;
        din = 32'h77;
        rdy = 1'b0;
        step();
        vin = 1'b0;
        chk("post_dout", a_dout, 32'h77);
        chk("post_vout", 32'(a_vout), 1);
        chk("post_cnt", 32'(a_cnt), 1);
        rdy = 1'b1;
        step();
        chk("post_cnt0", 32'(a_cnt), 0);
        chk("post_vout0", 32'(a_vout), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
